// File: rtl/camac_pkg.sv
// Shared types, function codes and helpers for the CAMAC dataway master.
package camac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStb1,
    StGap,
    StStb2,
    StHold
  } camac_state_e;

  localparam logic [4:0] F0  = 5'd0;
  localparam logic [4:0] F9  = 5'd9;
  localparam logic [4:0] F16 = 5'd16;
  localparam logic [4:0] F17 = 5'd17;
  localparam logic [4:0] F25 = 5'd25;
  localparam logic [4:0] F26 = 5'd26;
  localparam logic [4:0] F27 = 5'd27;

  // One bit wider than rsp_tries so QREP_MAX = 255 (256 cycles) cannot wrap.
  localparam int unsigned QrepCntW = 9;

  function automatic logic is_read_f(input logic [4:0] f);
    return (f <= 5'd7);
  endfunction

  function automatic logic is_write_f(input logic [4:0] f);
    return (f >= 5'd16) && (f <= 5'd23);
  endfunction

endpackage

// File: rtl/camac_phase_timer.sv
// Loadable 8-bit down-counter; done_o is high while the count sits at zero.
module camac_phase_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/camac_dataway_master.sv
// CAMAC crate-controller dataway master: runs one NAF cycle per accepted command.
// Optional Q-repeat is enabled by defining CAMAC_QREPEAT_EN.
module camac_dataway_master
  import camac_pkg::*;
#(
  parameter int unsigned SETUP_CLKS = 4,
  parameter int unsigned S1_CLKS    = 4,
  parameter int unsigned GAP_CLKS   = 2,
  parameter int unsigned S2_CLKS    = 4,
  parameter int unsigned HOLD_CLKS  = 2,
  parameter int unsigned QREP_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_n,
  input  logic [3:0]  cmd_a,
  input  logic [4:0]  cmd_f,
  input  logic [23:0] cmd_wdata,
  input  logic        cmd_qrep,
  output logic        rsp_valid,
  output logic [23:0] rsp_rdata,
  output logic        rsp_x,
  output logic        rsp_q,
  output logic [7:0]  rsp_tries,
  output logic [4:0]  camac_n,
  output logic [3:0]  camac_a,
  output logic [4:0]  camac_f,
  output logic [23:0] camac_w,
  output logic        camac_b,
  output logic        camac_s1,
  output logic        camac_s2,
  input  logic [23:0] camac_r,
  input  logic        camac_x,
  input  logic        camac_q
);

  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [7:0] SetupLd = 8'(SETUP_CLKS - 1);
  localparam logic [7:0] S1Ld    = 8'(S1_CLKS - 1);
  localparam logic [7:0] GapLd   = 8'(GAP_CLKS - 1);
  localparam logic [7:0] S2Ld    = 8'(S2_CLKS - 1);
  localparam logic [7:0] HoldLd  = 8'(HOLD_CLKS - 1);

  camac_state_e        state_q;
  logic                cmd_ready_q;
  logic [4:0]          n_q, f_q;
  logic [3:0]          a_q;
  logic [23:0]         w_q;
  logic                b_q, s1_q, s2_q;
  logic [23:0]         r_smp_q;
  logic                x_smp_q, q_smp_q;
  logic [QrepCntW-1:0] tries_q;
  logic                rsp_valid_q, rsp_x_q, rsp_q_q;
  logic [23:0]         rsp_rdata_q;
  logic [7:0]          rsp_tries_q;

  logic       accept;
  logic       repeat_go;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_done;

  assign accept = cmd_valid & cmd_ready_q;

`ifdef CAMAC_QREPEAT_EN
  logic qrep_q;
  assign repeat_go = qrep_q & ~q_smp_q & (tries_q <= QrepCntW'(QREP_MAX));
`else
  logic unused_qrep;
  assign unused_qrep = cmd_qrep | (QREP_MAX == 0);
  assign repeat_go   = 1'b0;
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    unique case (state_q)
      StIdle:  if (accept)   begin tmr_load = 1'b1; tmr_val = SetupLd; end
      StSetup: if (tmr_done) begin tmr_load = 1'b1; tmr_val = S1Ld;    end
      StStb1:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = GapLd;   end
      StGap:   if (tmr_done) begin tmr_load = 1'b1; tmr_val = S2Ld;    end
      StStb2:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = HoldLd;  end
      StHold:  if (tmr_done && repeat_go) begin tmr_load = 1'b1; tmr_val = SetupLd; end
      default: ;
    endcase
  end

  camac_phase_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      n_q         <= '0;
      a_q         <= '0;
      f_q         <= '0;
      w_q         <= '0;
      b_q         <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      r_smp_q     <= '0;
      x_smp_q     <= 1'b0;
      q_smp_q     <= 1'b0;
      tries_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_x_q     <= 1'b0;
      rsp_q_q     <= 1'b0;
      rsp_tries_q <= '0;
`ifdef CAMAC_QREPEAT_EN
      qrep_q      <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            n_q         <= cmd_n;
            a_q         <= cmd_a;
            f_q         <= cmd_f;
            w_q         <= is_write_f(cmd_f) ? cmd_wdata : 24'd0;
            b_q         <= 1'b1;
            cmd_ready_q <= 1'b0;
            tries_q     <= QrepCntW'(1);
            state_q     <= StSetup;
`ifdef CAMAC_QREPEAT_EN
            qrep_q      <= cmd_qrep;
`endif
          end
        end
        StSetup: begin
          if (tmr_done) begin
            s1_q    <= 1'b1;
            state_q <= StStb1;
          end
        end
        StStb1: begin
          if (tmr_done) begin
            s1_q    <= 1'b0;
            r_smp_q <= is_read_f(f_q) ? camac_r : 24'd0;
            x_smp_q <= camac_x;
            q_smp_q <= camac_q;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (tmr_done) begin
            s2_q    <= 1'b1;
            state_q <= StStb2;
          end
        end
        StStb2: begin
          if (tmr_done) begin
            s2_q    <= 1'b0;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (tmr_done) begin
            if (repeat_go) begin
              // Bus stays busy and NAF/W untouched across a Q-repeat.
              tries_q <= tries_q + QrepCntW'(1);
              state_q <= StSetup;
            end else begin
              n_q         <= '0;
              a_q         <= '0;
              f_q         <= '0;
              w_q         <= '0;
              b_q         <= 1'b0;
              cmd_ready_q <= 1'b1;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= r_smp_q;
              rsp_x_q     <= x_smp_q;
              rsp_q_q     <= q_smp_q;
              rsp_tries_q <= tries_q[QrepCntW-1] ? 8'hFF : tries_q[7:0];
              state_q     <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_tries = rsp_tries_q;
  assign camac_n   = n_q;
  assign camac_a   = a_q;
  assign camac_f   = f_q;
  assign camac_w   = w_q;
  assign camac_b   = b_q;
  assign camac_s1  = s1_q;
  assign camac_s2  = s2_q;

endmodule

// File: tb/tb_camac_dataway_master.sv
// Directed bench for camac_dataway_master; Q-repeat steps run when CAMAC_QREPEAT_EN is defined.
module tb_camac_dataway_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_qrep;
  logic [4:0]  cmd_n, cmd_f;
  logic [3:0]  cmd_a;
  logic [23:0] cmd_wdata;
  logic        rsp_valid, rsp_x, rsp_q;
  logic [23:0] rsp_rdata;
  logic [7:0]  rsp_tries;
  logic [4:0]  camac_n, camac_f;
  logic [3:0]  camac_a;
  logic [23:0] camac_w, camac_r;
  logic        camac_b, camac_s1, camac_s2, camac_x, camac_q;

  always #5 clk = ~clk;

  camac_dataway_master #(
    .SETUP_CLKS (4),
    .S1_CLKS    (4),
    .GAP_CLKS   (2),
    .S2_CLKS    (4),
    .HOLD_CLKS  (2),
    .QREP_MAX   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_n     (cmd_n),
    .cmd_a     (cmd_a),
    .cmd_f     (cmd_f),
    .cmd_wdata (cmd_wdata),
    .cmd_qrep  (cmd_qrep),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_x     (rsp_x),
    .rsp_q     (rsp_q),
    .rsp_tries (rsp_tries),
    .camac_n   (camac_n),
    .camac_a   (camac_a),
    .camac_f   (camac_f),
    .camac_w   (camac_w),
    .camac_b   (camac_b),
    .camac_s1  (camac_s1),
    .camac_s2  (camac_s2),
    .camac_r   (camac_r),
    .camac_x   (camac_x),
    .camac_q   (camac_q)
  );

  int tests = 0;
  int fails = 0;

  // Per-command observations; bit k of a mask is the value seen at edge T+k.
  logic [63:0] s1m, s2m, bm, vm, rdym;
  int          nafbad, idlebad, overlap, nvalid;
  logic [23:0] got_r;
  logic        got_x, got_q;
  logic [7:0]  got_tries;
  logic        q_mode, s1_seen;
  int          s1_num;
  int          acc [3];
  int          na;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and watch ncyc clocks after the accept edge.
  task automatic run_cmd(input logic [4:0] n, input logic [3:0] a, input logic [4:0] f,
                         input logic [23:0] w, input logic qrep, input int ncyc);
    logic [23:0] expw;
    expw = (f >= 5'd16 && f <= 5'd23) ? w : 24'd0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = n; cmd_a = a; cmd_f = f; cmd_wdata = w; cmd_qrep = qrep;
    @(posedge clk);
    s1m = '0; s2m = '0; bm = '0; vm = '0; rdym = '0;
    nafbad = 0; idlebad = 0; overlap = 0; nvalid = 0;
    s1_num = 0; s1_seen = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k < 64) begin
        s1m[k] = camac_s1; s2m[k] = camac_s2; bm[k] = camac_b;
        vm[k] = rsp_valid; rdym[k] = cmd_ready;
      end
      if (camac_s1 && camac_s2) overlap++;
      if (camac_b) begin
        if (camac_n !== n || camac_a !== a || camac_f !== f || camac_w !== expw) nafbad++;
      end else if ({camac_n, camac_a, camac_f, camac_w} !== '0) begin
        idlebad++;
      end
      if (rsp_valid) begin
        nvalid++; got_r = rsp_rdata; got_x = rsp_x; got_q = rsp_q; got_tries = rsp_tries;
      end
      // Station model for Q-repeat: Q answers 0 for the first two S1 pulses.
      if (camac_s1 && !s1_seen) begin
        s1_seen = 1'b1; s1_num++;
      end else if (!camac_s1) begin
        s1_seen = 1'b0;
      end
      if (q_mode) camac_q = (s1_num >= 3);
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_n = ~n; cmd_a = ~a; cmd_f = ~f; cmd_wdata = ~w;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_qrep = 1'b0;
    cmd_n = '0; cmd_a = '0; cmd_f = '0; cmd_wdata = '0;
    camac_r = 24'h00ABCD; camac_x = 1'b1; camac_q = 1'b1; q_mode = 1'b0;
    s1_num = 0; s1_seen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", cmd_ready, 1);
    check("reset_ctl", {camac_b, camac_s1, camac_s2, rsp_valid}, 0);
    check("reset_naf", {camac_n, camac_a, camac_f, camac_w}, 0);
    check("reset_rsp", {rsp_rdata, rsp_x, rsp_q, rsp_tries}, 0);
    rst = 1'b0;

    // F(0) read, N=1 A=0
    run_cmd(5'd1, 4'd0, 5'd0, 24'd0, 1'b0, 20);
    check("f0_s1_mask", s1m, 64'h1E0);
    check("f0_s2_mask", s2m, 64'h7800);
    check("f0_busy_mask", bm, 64'h1FFFE);
    check("f0_valid_mask", vm, 64'h20000);
    check("f0_ready_mask", rdym, 64'h1E0000);
    check("f0_rdata", got_r, 24'h00ABCD);
    check("f0_xq", {got_x, got_q}, 2'b11);
    check("f0_tries", got_tries, 1);
    check("f0_naf", nafbad + idlebad, 0);
    check("f0_overlap", overlap, 0);

    // F(16) write
    run_cmd(5'd3, 4'd2, 5'd16, 24'h123456, 1'b0, 20);
    check("f16_w_busy", nafbad, 0);
    check("f16_w_idle", idlebad, 0);
    check("f16_rdata", got_r, 24'd0);
    check("f16_busy_mask", bm, 64'h1FFFE);

    // F(27) with Q low
    camac_q = 1'b0;
    run_cmd(5'd5, 4'd1, 5'd27, 24'h000000, 1'b0, 20);
    check("f27_q", got_q, 1'b0);
    check("f27_x", got_x, 1'b1);
    check("f27_nvalid", nvalid, 1);
    camac_q = 1'b1;

    // F(9) and F(26): W must stay 0, F stable throughout
    run_cmd(5'd9, 4'd4, 5'd9, 24'hABCDEF, 1'b0, 20);
    check("f9_naf", nafbad + idlebad, 0);
    check("f9_busy_mask", bm, 64'h1FFFE);
    run_cmd(5'd23, 4'd15, 5'd26, 24'h555555, 1'b0, 20);
    check("f26_naf", nafbad + idlebad, 0);
    check("f26_rdata", got_r, 24'd0);

    // Abort with reset mid-S1
    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = 5'd7; cmd_a = 4'd3; cmd_f = 5'd17; cmd_wdata = 24'h0F0F0F;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
    end
    check("abort_pre_s1", camac_s1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ctl", {camac_s1, camac_s2, camac_b}, 0);
    check("abort_naf", {camac_n, camac_a, camac_f, camac_w}, 0);
    check("abort_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) nvalid++;
    end
    check("abort_no_rsp", nvalid, 0);

    // Back-to-back with cmd_valid held high
    na = 0; nvalid = 0; overlap = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    cmd_n = 5'd2; cmd_a = 4'd1; cmd_f = 5'd0; cmd_wdata = 24'd0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b1;
      if (na >= 3) cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (na < 3) acc[na] = k;
        na++;
      end
      if (rsp_valid) nvalid++;
      if (camac_s1 && camac_s2) overlap++;
    end
    check("b2b_accepts", na, 3);
    check("b2b_space1", acc[1] - acc[0], 17);
    check("b2b_space2", acc[2] - acc[1], 17);
    check("b2b_nvalid", nvalid, 3);
    check("b2b_overlap", overlap, 0);

`ifdef CAMAC_QREPEAT_EN
    q_mode = 1'b1;
    run_cmd(5'd4, 4'd0, 5'd0, 24'd0, 1'b1, 80);
    check("qrep_tries", got_tries, 3);
    check("qrep_q", got_q, 1'b1);
    check("qrep_nvalid", nvalid, 1);
    check("qrep_rdata", got_r, 24'h00ABCD);
    q_mode = 1'b0;
    camac_q = 1'b0;
    run_cmd(5'd4, 4'd0, 5'd0, 24'd0, 1'b1, 300);
    check("qstuck_tries", got_tries, 17);
    check("qstuck_q", got_q, 1'b0);
    check("qstuck_nvalid", nvalid, 1);
    camac_q = 1'b1;
`else
    camac_q = 1'b0;
    run_cmd(5'd4, 4'd0, 5'd0, 24'd0, 1'b1, 40);
    check("noqrep_tries", got_tries, 1);
    check("noqrep_nvalid", nvalid, 1);
    check("noqrep_q", got_q, 1'b0);
    camac_q = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
